// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception controller slice.
// Holds the decoder exception-cause encodings, the controller FSM state
// enum, the MRS system-register select encodings, the default handler
// entry address and the saturating counter helper.
package exception_ctrl_pkg;

  // Exception causes as seen in EStatus and stored in ESR.
  // ILLEGAL_RET is never driven by the decoder; the controller
  // synthesises it for an ERET outside a handler.
  typedef enum logic [3:0] {
    EST_NONE        = 4'b0000,
    EST_IRQ         = 4'b0001,
    EST_INVALID_OP  = 4'b0010,
    EST_ILLEGAL_RET = 4'b0011
  } estatus_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  // MRS source select.
  typedef enum logic [1:0] {
    SR_ELR = 2'b00,
    SR_ESR = 2'b01,
    SR_ERR = 2'b10,
    SR_CNT = 2'b11
  } sysreg_e;

  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'h0000_0000_0000_00D8;

  // Exception counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder <-> exception controller bus.
//   master : decoder/core side, drives cause, ERET flag, PC, instruction
//            and MRS select; receives redirect, ack and status outputs.
//   slave  : exception controller side.
// Signals:
//   EStatus[3:0]    exception cause (0 none, 1 IRQ, 2 invalid opcode)
//   ERet            current instruction is ERET
//   PC[63:0]        address of current instruction
//   Instr[31:0]     current instruction word
//   SysRegSel[1:0]  MRS source select (ELR/ESR/ERR/count)
//   Exc             take exception this cycle
//   NextPC[63:0]    redirect target when Exc or RetValid
//   RetValid        ERET accepted this cycle
//   ExcAck          one-cycle acknowledge to interrupting device
//   SysRegData[63:0] selected system register, zero-extended
//   InHandler       controller is in HANDLER
//   Halt            core locked after a double fault
interface exception_ctrl_if;
  logic [3:0]  EStatus;
  logic        ERet;
  logic [63:0] PC;
  logic [31:0] Instr;
  logic [1:0]  SysRegSel;
  logic        Exc;
  logic [63:0] NextPC;
  logic        RetValid;
  logic        ExcAck;
  logic [63:0] SysRegData;
  logic        InHandler;
  logic        Halt;

  modport master (
    output EStatus, ERet, PC, Instr, SysRegSel,
    input  Exc, NextPC, RetValid, ExcAck, SysRegData, InHandler, Halt
  );

  modport slave (
    input  EStatus, ERet, PC, Instr, SysRegSel,
    output Exc, NextPC, RetValid, ExcAck, SysRegData, InHandler, Halt
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller: takes exceptions from the decoder, saves the
// faulting context (ELR/ESR/ERR), counts exceptions, handles ERET and
// locks the core on a double fault.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns to RUN and clears context
//   bus    exception_ctrl_if.slave (see interface file for signal list)
// Parameter:
//   EXC_VECTOR  handler entry address driven on NextPC when Exc is taken
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [63:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  exception_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [63:0] elr_q, elr_d;
  logic [3:0]  esr_q, esr_d;
  logic [31:0] err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [3:0]  cause;

  always_comb begin
    state_d       = state_q;
    elr_d         = elr_q;
    esr_d         = esr_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    ack_d         = 1'b0;
    cause         = EST_NONE;
    bus.Exc       = 1'b0;
    bus.RetValid  = 1'b0;
    bus.NextPC    = '0;
    bus.Halt      = 1'b0;
    bus.InHandler = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A decoder cause beats ERET; a bare ERET in RUN is itself a fault.
        if (bus.EStatus != EST_NONE) cause = bus.EStatus;
        else if (bus.ERet)           cause = EST_ILLEGAL_RET;

        if (cause != EST_NONE) begin
          bus.Exc    = 1'b1;
          bus.NextPC = EXC_VECTOR;
          elr_d      = bus.PC;
          esr_d      = cause;
          err_d      = bus.Instr;
          cnt_d      = sat_inc16(cnt_q);
          ack_d      = (cause == EST_IRQ);
          state_d    = ST_HANDLER;
        end
      end

      ST_HANDLER: begin
        bus.InHandler = 1'b1;
        // IRQs are masked here and stay pending at the device; ERET wins
        // over any cause so a pending IRQ is re-evaluated back in RUN.
        if (bus.ERet) begin
          bus.RetValid = 1'b1;
          bus.NextPC   = elr_q;
          state_d      = ST_RUN;
        end else if (bus.EStatus == EST_INVALID_OP) begin
          state_d = ST_FAULT;
        end
      end

      ST_FAULT: begin
        bus.Halt = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset overrides everything in its own cycle, including outputs.
    if (reset) begin
      bus.Exc       = 1'b0;
      bus.RetValid  = 1'b0;
      bus.NextPC    = '0;
      bus.Halt      = 1'b0;
      bus.InHandler = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      elr_q   <= '0;
      esr_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ExcAck = ack_q & ~reset;

  // MRS read path reflects current register contents only.
  always_comb begin
    bus.SysRegData = '0;
    case (bus.SysRegSel)
      SR_ELR:  bus.SysRegData = elr_q;
      SR_ESR:  bus.SysRegData = {60'd0, esr_q};
      SR_ERR:  bus.SysRegData = {32'd0, err_q};
      SR_CNT:  bus.SysRegData = {48'd0, cnt_q};
      default: bus.SysRegData = '0;
    endcase
  end

endmodule
